div_counter: RTL
================

DIV_COUNTER -- requirements
Module: div_counter

Interface
REQ-001 Parameter: WIDTH, 32, bit width of count_target and count_value; legal range 2..32.
REQ-002 Port: count_in  input  1  clock; all state updates on its rising edge.
REQ-003 Port: count_reset_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: count_enable  input  1  count qualifier; count advances only in cycles where it is high.
REQ-005 Port: count_start  input  1  synchronous start pulse; latches target and mode, begins a run.
REQ-006 Port: count_stop  input  1  synchronous abort to IDLE.
REQ-007 Port: count_mode  input  1  0 = one-shot, 1 = periodic (divider).
REQ-008 Port: count_target  input  WIDTH  terminal count N; sampled only when count_start is high.
REQ-009 Port: count_value  output  WIDTH  current count, registered.
REQ-010 Port: count_busy  output  1  high while in RUN.
REQ-011 Port: count_completed  output  1  one-shot done level, held until start, stop or reset.
REQ-012 Port: count_tick  output  1  one-cycle registered pulse at each terminal count.

Function
REQ-013 FSM states: IDLE, RUN, DONE; count_busy = (state==RUN).
REQ-014 count_start in any state with count_target != 0: latch target_q <= count_target, mode_q <= count_mode, count_value <= 0, count_completed <= 0, state <= RUN.
REQ-015 count_start with count_target == 0: state <= IDLE, count_value <= 0, count_completed <= 0, no tick.
REQ-016 count_start and count_stop in the same cycle: count_start wins.
REQ-017 count_stop without count_start: state <= IDLE, count_value <= 0, count_completed <= 0, count_tick <= 0.
REQ-018 RUN, count_enable=0: count_value, state, count_completed held; count_tick <= 0.
REQ-019 RUN, count_enable=1, count_value != target_q-1: count_value <= count_value+1, count_tick <= 0.
REQ-020 RUN, count_enable=1, count_value == target_q-1: count_tick <= 1, count_value <= 0.
REQ-021 In REQ-020 with mode_q=0: state <= DONE, count_completed <= 1; with mode_q=1: state stays RUN.
REQ-022 Latency: count_tick and count_completed are high in the cycle after the edge that consumed the Nth enabled cycle after start.
REQ-023 Periodic mode with count_enable held high: count_tick period is exactly target_q cycles, duty one cycle; target_q=1 gives count_tick continuously high.
REQ-024 DONE: count_value held at 0, no counting regardless of count_enable, count_completed high, count_tick low after its single pulse.
REQ-025 Changes on count_target or count_mode while not starting have no effect on the current run.
REQ-026 Arithmetic is unsigned modulo 2^WIDTH; target_q = 2^WIDTH-1 counts 0..2^WIDTH-2 without overflow.

Reset
REQ-027 count_reset_n low asynchronously forces state=IDLE, count_value=0, target_q=0, mode_q=0, count_busy=0, count_completed=0, count_tick=0.
REQ-028 Reset assertion mid-run discards the run; after release the block stays in IDLE until count_start.
REQ-029 Reset release is synchronous to count_in by the integrator; the block adds no synchronizer.

Configuration
REQ-030 Macro DIV_COUNTER_TOGGLE_EN defined: extra port count_toggle output 1 (registered 50%-style divided output).
REQ-031 With DIV_COUNTER_TOGGLE_EN: count_toggle inverts in the same cycle count_tick is set, is cleared by reset, count_start and count_stop, and holds otherwise.
REQ-032 Without DIV_COUNTER_TOGGLE_EN: count_toggle port and its register are absent; all other behaviour is identical.

Verification
REQ-033 One-shot: WIDTH=32, start target=5 mode=0, enable high -> count_value 0,1,2,3,4,0; count_tick one pulse 5 cycles after start; count_completed high and held; count_busy low.
REQ-034 Periodic: start target=3 mode=1, enable high 12 cycles -> count_tick high on cycles 3,6,9,12; with macro, count_toggle 1,0,1,0 at those edges.
REQ-035 Gated: target=4 mode=0, enable pattern 1,0,1,1,0,1 -> tick/completed after the 6th cycle only; count_value holds during enable=0.
REQ-036 Boundaries: start target=0 -> state IDLE, busy low, no tick; start target=1 mode=1 -> count_tick high every enabled cycle.
REQ-037 Abort/restart: mid-run at count_value=2, start and stop together with target=7 -> count_value 0, busy high, new 7-cycle run; stop alone -> IDLE, count_value 0.
REQ-038 Reset: assert count_reset_n low mid-run between clock edges -> all outputs 0 immediately; after release no counting until count_start.

Source files
------------

// File: rtl/div_counter.sv
// Programmable terminal-count divider: one-shot or periodic runs with tick and done outputs.
// Optional registered divided output count_toggle when DIV_COUNTER_TOGGLE_EN is defined.
module div_counter #(
  parameter int WIDTH = 32
) (
  input  logic             count_in,
  input  logic             count_reset_n,
  input  logic             count_enable,
  input  logic             count_start,
  input  logic             count_stop,
  input  logic             count_mode,
  input  logic [WIDTH-1:0] count_target,
  output logic [WIDTH-1:0] count_value,
  output logic             count_busy,
  output logic             count_completed,
  output logic             count_tick
`ifdef DIV_COUNTER_TOGGLE_EN
  ,
  output logic             count_toggle
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_r, state_s;
  logic [WIDTH-1:0] target_r, target_s;
  logic             mode_r, mode_s;
  logic [WIDTH-1:0] value_r, value_s;
  logic             busy_r, busy_s;
  logic             completed_r, completed_s;
  logic             tick_r, tick_s;
  logic             term_s;
`ifdef DIV_COUNTER_TOGGLE_EN
  logic             toggle_r, toggle_s;
`endif

  // Last count of the period; unsigned wrap keeps target 2^WIDTH-1 in range.
  assign term_s = (value_r == (target_r - CNT_ONE));

  // Next-state and next-output computation; start has priority over stop.
  always_comb begin
    state_s     = state_r;
    target_s    = target_r;
    mode_s      = mode_r;
    value_s     = value_r;
    completed_s = completed_r;
    tick_s      = 1'b0;
`ifdef DIV_COUNTER_TOGGLE_EN
    toggle_s    = toggle_r;
`endif
    if (count_start) begin
      value_s     = CNT_ZERO;
      completed_s = 1'b0;
`ifdef DIV_COUNTER_TOGGLE_EN
      toggle_s    = 1'b0;
`endif
      if (count_target != CNT_ZERO) begin
        target_s = count_target;
        mode_s   = count_mode;
        state_s  = ST_RUN;
      end else begin
        state_s  = ST_IDLE;
      end
    end else if (count_stop) begin
      state_s     = ST_IDLE;
      value_s     = CNT_ZERO;
      completed_s = 1'b0;
`ifdef DIV_COUNTER_TOGGLE_EN
      toggle_s    = 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_IDLE;
        end
        ST_RUN: begin
          if (count_enable) begin
            if (term_s) begin
              value_s = CNT_ZERO;
              tick_s  = 1'b1;
`ifdef DIV_COUNTER_TOGGLE_EN
              toggle_s = ~toggle_r;
`endif
              if (mode_r) begin
                state_s = ST_RUN;
              end else begin
                state_s     = ST_DONE;
                completed_s = 1'b1;
              end
            end else begin
              value_s = value_r + CNT_ONE;
            end
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_DONE: begin
          value_s = CNT_ZERO;
        end
        default: begin
          state_s     = ST_IDLE;
          value_s     = CNT_ZERO;
          completed_s = 1'b0;
        end
      endcase
    end
    busy_s = (state_s == ST_RUN);
  end

  // State and output registers.
  always_ff @(posedge count_in or negedge count_reset_n) begin
    if (!count_reset_n) begin
      state_r     <= ST_IDLE;
      target_r    <= CNT_ZERO;
      mode_r      <= 1'b0;
      value_r     <= CNT_ZERO;
      busy_r      <= 1'b0;
      completed_r <= 1'b0;
      tick_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      target_r    <= target_s;
      mode_r      <= mode_s;
      value_r     <= value_s;
      busy_r      <= busy_s;
      completed_r <= completed_s;
      tick_r      <= tick_s;
    end
  end

`ifdef DIV_COUNTER_TOGGLE_EN
  // Divided output register.
  always_ff @(posedge count_in or negedge count_reset_n) begin
    if (!count_reset_n) begin
      toggle_r <= 1'b0;
    end else begin
      toggle_r <= toggle_s;
    end
  end

  assign count_toggle = toggle_r;
`endif

  assign count_value     = value_r;
  assign count_busy      = busy_r;
  assign count_completed = completed_r;
  assign count_tick      = tick_r;

endmodule
